// File: rtl/dec.sv
// dec: RV32I decode stage. It cracks IF/ID, detects load-use hazards and owns the ID/EX register.
// Build option: define DEC_ILLEGAL_EN to flag unrecognised encodings on o_illegal.
module dec #(
  parameter logic [31:0] NOP_INST  = 32'h00000033,
  parameter logic [31:0] HALT_INST = 32'h00100073
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic        i_vld,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  output logic        o_hold,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  output logic [31:0] o_immediate,
  output logic [4:0]  o_rd_waddr,
  output logic [2:0]  o_opsel,
  output logic        o_sub,
  output logic        o_alu_imm,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic        o_lui,
  output logic        o_auipc,
  output logic        o_halt,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld,
  output logic        o_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [31:0] form_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                       inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'h000};
      OP_JAL:                   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                       inst[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_r, is_imm, is_load, is_store, is_branch;
  logic       is_jalr, is_jal, is_lui, is_auipc, is_nop;
  logic       uses_rs1, uses_rs2, writes_rd, ill, bubble;

  assign opc       = i_inst[6:0];
  assign f3        = i_inst[14:12];
  assign rd        = i_inst[11:7];
  assign is_r      = (opc == OP_R);
  assign is_imm    = (opc == OP_IMM);
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jalr   = (opc == OP_JALR);
  assign is_jal    = (opc == OP_JAL);
  assign is_lui    = (opc == OP_LUI);
  assign is_auipc  = (opc == OP_AUIPC);
  assign is_nop    = (i_inst == NOP_INST);

  assign uses_rs1  = is_r | is_imm | is_load | is_jalr | is_store | is_branch;
  assign uses_rs2  = is_r | is_store | is_branch;
  assign writes_rd = (is_r | is_imm | is_load | is_jal | is_jalr | is_lui | is_auipc)
                     & (rd != 5'd0) & ~is_nop;

`ifdef DEC_ILLEGAL_EN
  logic is_system, is_fence, known_op, f3_bad;

  assign is_system = (opc == 7'b1110011);
  assign is_fence  = (opc == 7'b0001111);
  assign known_op  = is_r | is_imm | is_load | is_store | is_branch | is_jalr | is_jal
                     | is_lui | is_auipc | is_system | is_fence;
  // Holes in the funct3 space of the memory and control-transfer groups
  assign f3_bad    = (is_load   & ((f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7)))
                   | (is_store  & (f3 > 3'd2))
                   | (is_branch & ((f3 == 3'd2) | (f3 == 3'd3)))
                   | (is_jalr   & (f3 != 3'd0));
  assign ill       = ~known_op | f3_bad;
`else
  assign ill       = 1'b0;
`endif

  assign o_rs1_raddr = i_inst[19:15];
  assign o_rs2_raddr = i_inst[24:20];

  // A load in EX whose rd feeds the instruction in ID must wait one cycle
  assign o_hold = o_vld & o_mem_read & (o_rd_waddr != 5'd0) & i_vld & ~i_flush
                & ((uses_rs1 & (o_rs1_raddr == o_rd_waddr))
                 | (uses_rs2 & (o_rs2_raddr == o_rd_waddr)));

  assign bubble = i_flush | o_hold;

  logic [31:0] rs1_d, rs2_d, imm_d, pc_d, nxt_pc_d;
  logic [31:0] rs1_q, rs2_q, imm_q, pc_q, nxt_pc_q;
  logic [4:0]  rd_d, rd_q;
  logic [2:0]  opsel_d, opsel_q;
  logic        sub_d, alu_imm_d, branch_d, jal_d, jalr_d, mem_read_d, mem_write_d;
  logic        reg_write_d, lui_d, auipc_d, halt_d, vld_d, illegal_d;
  logic        sub_q, alu_imm_q, branch_q, jal_q, jalr_q, mem_read_q, mem_write_q;
  logic        reg_write_q, lui_q, auipc_q, halt_q, vld_q, illegal_q;

  always_comb begin
    rs1_d       = '0;
    rs2_d       = '0;
    imm_d       = '0;
    pc_d        = '0;
    nxt_pc_d    = '0;
    rd_d        = '0;
    opsel_d     = '0;
    sub_d       = 1'b0;
    alu_imm_d   = 1'b0;
    branch_d    = 1'b0;
    jal_d       = 1'b0;
    jalr_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    lui_d       = 1'b0;
    auipc_d     = 1'b0;
    halt_d      = 1'b0;
    vld_d       = 1'b0;
    illegal_d   = 1'b0;
    if (!bubble) begin
      rs1_d     = i_rs1_rdata;
      rs2_d     = i_rs2_rdata;
      imm_d     = form_imm(i_inst);
      pc_d      = i_pc;
      nxt_pc_d  = i_nxt_pc;
      rd_d      = rd;
      opsel_d   = f3;
      sub_d     = i_inst[30] & (is_r | (is_imm & (f3[1:0] == 2'b01)));
      alu_imm_d = is_imm | is_load | is_store | is_jalr | is_lui | is_auipc;
      vld_d     = i_vld;
      illegal_d = i_vld & ill;
      // Strobes only for a valid, legal instruction
      if (i_vld && !ill) begin
        branch_d    = is_branch;
        jal_d       = is_jal;
        jalr_d      = is_jalr;
        mem_read_d  = is_load;
        mem_write_d = is_store;
        reg_write_d = writes_rd;
        lui_d       = is_lui;
        auipc_d     = is_auipc;
        halt_d      = (i_inst == HALT_INST);
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      nxt_pc_q    <= '0;
      rd_q        <= '0;
      opsel_q     <= '0;
      sub_q       <= 1'b0;
      alu_imm_q   <= 1'b0;
      branch_q    <= 1'b0;
      jal_q       <= 1'b0;
      jalr_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      lui_q       <= 1'b0;
      auipc_q     <= 1'b0;
      halt_q      <= 1'b0;
      vld_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      nxt_pc_q    <= nxt_pc_d;
      rd_q        <= rd_d;
      opsel_q     <= opsel_d;
      sub_q       <= sub_d;
      alu_imm_q   <= alu_imm_d;
      branch_q    <= branch_d;
      jal_q       <= jal_d;
      jalr_q      <= jalr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      lui_q       <= lui_d;
      auipc_q     <= auipc_d;
      halt_q      <= halt_d;
      vld_q       <= vld_d;
      illegal_q   <= illegal_d;
    end
  end

  assign o_rs1       = rs1_q;
  assign o_rs2       = rs2_q;
  assign o_immediate = imm_q;
  assign o_pc        = pc_q;
  assign o_nxt_pc    = nxt_pc_q;
  assign o_rd_waddr  = rd_q;
  assign o_opsel     = opsel_q;
  assign o_sub       = sub_q;
  assign o_alu_imm   = alu_imm_q;
  assign o_branch    = branch_q;
  assign o_jal       = jal_q;
  assign o_jalr      = jalr_q;
  assign o_mem_read  = mem_read_q;
  assign o_mem_write = mem_write_q;
  assign o_reg_write = reg_write_q;
  assign o_lui       = lui_q;
  assign o_auipc     = auipc_q;
  assign o_halt      = halt_q;
  assign o_vld       = vld_q;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_dec.sv
// tb_dec: directed and randomized checks of dec against a spec-level reference model.
module tb_dec;
  localparam logic [31:0] NOP  = 32'h00000033;
  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] LW5  = 32'h00012283;  // lw  x5,0(x2)
  localparam logic [31:0] ADD6 = 32'h00128333;  // add x6,x5,x1

  logic        i_clk = 1'b0;
  logic        i_rst, i_vld, i_flush;
  logic [31:0] i_inst, i_pc, i_nxt_pc, i_rs1_rdata, i_rs2_rdata;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd_waddr;
  logic        o_hold, o_sub, o_alu_imm, o_branch, o_jal, o_jalr, o_mem_read, o_mem_write;
  logic        o_reg_write, o_lui, o_auipc, o_halt, o_vld, o_illegal;
  logic [31:0] o_rs1, o_rs2, o_immediate, o_pc, o_nxt_pc;
  logic [2:0]  o_opsel;

  always #5 i_clk = ~i_clk;

  dec dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
    .i_vld(i_vld), .i_flush(i_flush), .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .o_hold(o_hold),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_immediate(o_immediate), .o_rd_waddr(o_rd_waddr),
    .o_opsel(o_opsel), .o_sub(o_sub), .o_alu_imm(o_alu_imm), .o_branch(o_branch),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_reg_write(o_reg_write), .o_lui(o_lui), .o_auipc(o_auipc), .o_halt(o_halt),
    .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_vld(o_vld), .o_illegal(o_illegal)
  );

  // stb = {branch, jal, jalr, mem_read, mem_write, reg_write, lui, auipc, halt}
  typedef struct packed {
    logic [31:0] rs1, rs2, imm, pc, npc;
    logic [4:0]  rd;
    logic [2:0]  opsel;
    logic        sub, alu_imm, vld, illegal;
    logic [8:0]  stb;
  } exp_t;

  exp_t ev = '0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic v);
    exp_t e;
    int   imm;
    bit   known, badf3, wr;
    logic [2:0] f3;
    e = '0; imm = 0; known = 1; badf3 = 0; wr = 0;
    f3 = in[14:12];
    e.rs1 = r1; e.rs2 = r2; e.pc = pc; e.npc = pc + 32'd4;
    e.rd = in[11:7]; e.opsel = f3; e.vld = v;
    case (in[6:0])
      7'h33: begin wr = 1; e.sub = in[30]; end
      7'h13: begin
        wr = 1; e.alu_imm = 1;
        imm = int'(in[30:20]) - (in[31] ? 2048 : 0);
        if (f3 == 3'd1 || f3 == 3'd5) e.sub = in[30];
      end
      7'h03: begin
        wr = 1; e.stb[5] = 1; e.alu_imm = 1;
        imm = int'(in[30:20]) - (in[31] ? 2048 : 0);
        badf3 = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        e.stb[4] = 1; e.alu_imm = 1;
        imm = int'(in[30:25]) * 32 + int'(in[11:7]) - (in[31] ? 2048 : 0);
        badf3 = (f3 > 2);
      end
      7'h63: begin
        e.stb[8] = 1;
        imm = int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2
            - (in[31] ? 4096 : 0);
        badf3 = (f3 == 2 || f3 == 3);
      end
      7'h67: begin
        wr = 1; e.stb[6] = 1; e.alu_imm = 1;
        imm = int'(in[30:20]) - (in[31] ? 2048 : 0);
        badf3 = (f3 != 0);
      end
      7'h6F: begin
        wr = 1; e.stb[7] = 1;
        imm = int'(in[19:12]) * 4096 + int'(in[20]) * 2048 + int'(in[30:21]) * 2
            - (in[31] ? 1048576 : 0);
      end
      7'h37: begin wr = 1; e.stb[2] = 1; e.alu_imm = 1; imm = int'(in[31:12] * 4096); end
      7'h17: begin wr = 1; e.stb[1] = 1; e.alu_imm = 1; imm = int'(in[31:12] * 4096); end
      7'h73: e.stb[0] = (in == HALT);
      7'h0F: ;
      default: known = 0;
    endcase
    e.imm = imm;
    e.stb[3] = wr && (in[11:7] != 0);
`ifdef DEC_ILLEGAL_EN
    if (!known || badf3) begin
      e.stb = '0;
      e.illegal = v;
    end
`endif
    if (!v) e.stb = '0;
    return e;
  endfunction

  function automatic logic exp_hold(input logic [31:0] in, input logic v, input logic fl);
    logic u1, u2;
    u1 = (in[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    u2 = (in[6:0] inside {7'h33, 7'h23, 7'h63});
    return ev.vld && ev.stb[5] && ev.rd != 0 && v && !fl
        && ((u1 && in[19:15] == ev.rd) || (u2 && in[24:20] == ev.rd));
  endfunction

  task automatic step(input logic rst, input logic v, input logic fl, input logic [31:0] inst,
                      input logic [31:0] pc, output logic eh, output logic ho);
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    i_rst = rst; i_vld = v; i_flush = fl; i_inst = inst; i_pc = pc; i_nxt_pc = pc + 32'd4;
    i_rs1_rdata = r1; i_rs2_rdata = r2;
    #1;
    eh = exp_hold(inst, v, fl);
    ho = o_hold;
    check("hold", o_hold, eh);
    check("raddr1", o_rs1_raddr, inst[19:15]);
    check("raddr2", o_rs2_raddr, inst[24:20]);
    @(posedge i_clk);
    if (rst || fl || eh) ev = '0;
    else ev = model(inst, pc, r1, r2, v);
    #1;
    check("rs1", o_rs1, ev.rs1);
    check("rs2", o_rs2, ev.rs2);
    check("imm", o_immediate, ev.imm);
    check("pc", {o_pc, o_nxt_pc}, {ev.pc, ev.npc});
    check("rd_opsel", {o_rd_waddr, o_opsel, o_sub, o_alu_imm},
          {ev.rd, ev.opsel, ev.sub, ev.alu_imm});
    check("strobes", {o_branch, o_jal, o_jalr, o_mem_read, o_mem_write, o_reg_write,
                      o_lui, o_auipc, o_halt}, ev.stb);
    check("vld_ill", {o_vld, o_illegal}, {ev.vld, ev.illegal});
  endtask

  function automatic logic [31:0] gen();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [31:0] r;
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    r  = $urandom;
    case ($urandom_range(0, 12))
      0:  return {1'b0, r[30], 5'b0, r2, r1, f3, rd, 7'h33};
      1:  return {r[31:20], r1, f3, rd, 7'h13};
      2:  return {r[31:20], r1, f3, rd, 7'h03};
      3:  return {r[31:25], r2, r1, f3, r[11:7], 7'h23};
      4:  return {r[31:25], r2, r1, f3, r[11:7], 7'h63};
      5:  return {r[31:20], r1, f3, rd, 7'h67};
      6:  return {r[31:12], rd, 7'h6F};
      7:  return {r[31:12], rd, 7'h37};
      8:  return {r[31:12], rd, 7'h17};
      9:  return HALT;
      10: return NOP;
      11: return {r[31:7], 7'h7F};
      default: return r;
    endcase
  endfunction

  initial begin
    logic        eh, ho, held, v, fl, rst;
    logic [31:0] inst, pc;
    i_rst = 1; i_vld = 0; i_flush = 0; i_inst = NOP; i_pc = 0; i_nxt_pc = 4;
    i_rs1_rdata = 0; i_rs2_rdata = 0;
    @(posedge i_clk); #1;

    step(1, 0, 0, NOP, 32'h0, eh, ho);
    step(1, 1, 0, LW5, 32'h100, eh, ho);
    check("rst_vld", o_vld, 1'b0);
    check("rst_imm", o_immediate, 32'h0);

    step(0, 1, 0, 32'hFFF00093, 32'h200, eh, ho);
    check("addi_imm", o_immediate, 32'hFFFFFFFF);
    check("addi_rd", o_rd_waddr, 5'd1);
    check("addi_wr", o_reg_write, 1'b1);
    check("addi_aluimm", o_alu_imm, 1'b1);

    step(0, 1, 0, LW5, 32'h300, eh, ho);
    step(0, 1, 0, ADD6, 32'h304, eh, ho);
    check("lu_hold", ho, 1'b1);
    check("lu_bubble", o_vld, 1'b0);
    step(0, 1, 0, ADD6, 32'h304, eh, ho);
    check("lu_release", ho, 1'b0);
    check("lu_issue_vld", o_vld, 1'b1);
    check("lu_issue_rd", o_rd_waddr, 5'd6);

    step(0, 1, 0, LW5, 32'h400, eh, ho);
    step(0, 1, 1, ADD6, 32'h404, eh, ho);
    check("flush_nohold", ho, 1'b0);
    check("flush_bubble", o_vld, 1'b0);

    step(0, 1, 0, 32'hFE000EE3, 32'h500, eh, ho);
    check("beq_branch", o_branch, 1'b1);
    check("beq_imm", o_immediate, 32'hFFFFFFFC);
    check("beq_wr", o_reg_write, 1'b0);

    step(0, 1, 0, 32'h0000007F, 32'h600, eh, ho);
`ifdef DEC_ILLEGAL_EN
    check("bad_illegal", o_illegal, 1'b1);
`else
    check("bad_illegal", o_illegal, 1'b0);
`endif
    check("bad_vld", o_vld, 1'b1);
    check("bad_strobes", {o_branch, o_jal, o_jalr, o_mem_read, o_mem_write, o_reg_write,
                          o_lui, o_auipc, o_halt}, 9'h0);

    step(0, 1, 0, HALT, 32'h700, eh, ho);
    check("halt", o_halt, 1'b1);
    step(0, 1, 0, NOP, 32'h704, eh, ho);
    check("nop_vld", o_vld, 1'b1);
    check("nop_wr", o_reg_write, 1'b0);

    step(0, 1, 0, LW5, 32'h800, eh, ho);
    step(1, 1, 0, ADD6, 32'h804, eh, ho);
    check("rst_stall_hold", ho, 1'b1);
    step(0, 1, 0, ADD6, 32'h804, eh, ho);
    check("rst_stall_clear", ho, 1'b0);

    held = 0; inst = NOP; pc = 0; v = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!held) begin
        inst = gen();
        pc   = {$urandom_range(0, 32'h3FFF), 2'b00};
        v    = ($urandom_range(0, 99) < 85);
      end
      fl  = ($urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 99) < 2);
      step(rst, v, fl, inst, pc, eh, ho);
      held = eh && !rst;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
